prim_reg_slice: RTL and testbench



---
 rtl/prim_reg_slice_pkg.sv | 23 ++
 rtl/prim_reg_slice_flop.sv | 20 ++
 rtl/prim_reg_slice.sv | 118 +++++++++++
 tb/tb_prim_reg_slice.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/prim_reg_slice_pkg.sv
// Shared types for the two-entry valid/ready register slice: controller
// state encoding and the occupancy reported for each state.
package prim_reg_slice_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  localparam logic [1:0] DEPTH_EMPTY = 2'd0;
  localparam logic [1:0] DEPTH_BUSY  = 2'd1;
  localparam logic [1:0] DEPTH_FULL  = 2'd2;

  function automatic logic [1:0] depth_of(state_e st);
    case (st)
      ST_BUSY: depth_of = DEPTH_BUSY;
      ST_FULL: depth_of = DEPTH_FULL;
      default: depth_of = DEPTH_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/prim_reg_slice_flop.sv
// Generic async-reset flop bank; any hold/enable muxing lives in the caller.
module prim_reg_slice_flop #(
  parameter int               Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= ResetValue;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/prim_reg_slice.sv
// Two-entry skid buffer: main register feeds data_o, skid register absorbs
// the beat that arrives while downstream stalls. All outputs decode from state.
module prim_reg_slice
  import prim_reg_slice_pkg::*;
#(
  parameter int               Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       depth_o
);

  state_e             state_q, state_d;
  logic [1:0]         state_raw;
  logic               main_en, skid_en, main_from_skid;
  logic [Width-1:0]   main_q, main_d;
  logic [Width-1:0]   skid_q, skid_d;

  prim_reg_slice_flop #(
    .Width     (2),
    .ResetValue(ST_EMPTY)
  ) u_state (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (state_d),
    .q_o   (state_raw)
  );

  assign state_q = state_e'(state_raw);

  // Flush has top priority and suppresses every load that cycle.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (valid_i) begin
            main_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (valid_i && ready_i) begin
            main_en = 1'b1;
          end else if (valid_i) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (ready_i) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (ready_i) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_en ? (main_from_skid ? skid_q : data_i) : main_q;
  assign skid_d = skid_en ? data_i : skid_q;

  prim_reg_slice_flop #(
    .Width     (Width),
    .ResetValue(ResetValue)
  ) u_main (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  prim_reg_slice_flop #(
    .Width     (Width),
    .ResetValue(ResetValue)
  ) u_skid (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (skid_d),
    .q_o   (skid_q)
  );

  assign valid_o = (state_q != ST_EMPTY);
  assign ready_o = (state_q != ST_FULL);
  assign depth_o = depth_of(state_q);
  assign data_o  = main_q;

  // A flush releases a stalled upstream, so it is exempt from the stability rule.
  a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o && !flush_i) |=> valid_i);

  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o && !flush_i) |=> $stable(data_i));

  a_full_not_to_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == ST_FULL && !flush_i) |=> (state_q != ST_EMPTY));

  a_legal_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_raw != 2'b11));

endmodule

// File: tb/tb_prim_reg_slice.sv
// Bench for prim_reg_slice: directed scenarios plus random backpressure,
// checked by a queue-based reference model in a negedge monitor.
module tb_prim_reg_slice;

  localparam int          W     = 32;
  localparam logic [31:0] RVAL  = 32'hDEAD_BEEF;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  data_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [W-1:0]  data_o;
  logic [1:0]    depth_o;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  bit last_accept = 1'b0;
  logic [31:0] exp_q[$];

  prim_reg_slice #(.Width(W), .ResetValue(RVAL)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .depth_o(depth_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity two. Acceptance and delivery are
  // decided from the model occupancy, never from the DUT handshake outputs.
  always @(negedge clk_i) begin
    int sz;
    bit acc;
    if (!rst_ni) begin
      chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
      chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
      chk("rst_depth_o", {30'b0, depth_o}, 32'd0);
      chk("rst_data_o", data_o, RVAL);
      exp_q.delete();
      last_accept = 1'b0;
    end else begin
      sz = exp_q.size();
      chk("valid_o", {31'b0, valid_o}, {31'b0, sz != 0});
      chk("ready_o", {31'b0, ready_o}, {31'b0, sz < 2});
      chk("depth_o", {30'b0, depth_o}, sz);
      if (sz != 0) chk("data_o", data_o, exp_q[0]);
      if (flush_i) begin
        exp_q.delete();
        last_accept = 1'b0;
      end else begin
        acc = valid_i && (sz < 2);
        if (sz != 0 && ready_i) begin
          void'(exp_q.pop_front());
          delivered++;
        end
        if (acc) exp_q.push_back(data_i);
        last_accept = acc;
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int offered;
    int guard;
    int base_deliv;

    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_data_o", data_o, RVAL);
    chk("reset_depth_o", {30'b0, depth_o}, 32'd0);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(0, 0, 0, 0);

    // Streaming 1..16 at full throughput
    base_deliv = delivered;
    for (int i = 1; i <= 16; i++) step(1, i, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("stream_count", delivered - base_deliv, 32'd16);

    // Stall fill then drain
    step(1, 32'h11, 0, 0);
    step(1, 32'h22, 0, 0);
    chk("stall_depth", {30'b0, depth_o}, 32'd2);
    chk("stall_ready", {31'b0, ready_o}, 32'd0);
    repeat (3) step(0, 0, 0, 0);
    chk("stall_hold_data", data_o, 32'h11);
    step(0, 0, 1, 0);
    chk("drain1_depth", {30'b0, depth_o}, 32'd1);
    chk("drain1_data", data_o, 32'h22);
    step(0, 0, 1, 0);
    chk("drain2_depth", {30'b0, depth_o}, 32'd0);

    // Flush while FULL with a concurrent input beat
    step(1, 32'h33, 0, 0);
    step(1, 32'h44, 0, 0);
    step(1, 32'h55, 1, 1);
    chk("flush_valid", {31'b0, valid_o}, 32'd0);
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    repeat (4) step(0, 0, 1, 0);

    // Async reset mid-stall
    step(1, 32'h66, 0, 0);
    step(1, 32'h77, 0, 0);
    valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid_o}, 32'd0);
    chk("async_rst_data", data_o, RVAL);
    chk("async_rst_depth", {30'b0, depth_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Random backpressure, 1000 incrementing beats
    base_deliv = delivered;
    offered = 0;
    guard = 0;
    valid_i = 1'b0;
    while ((offered < 1000 || (valid_i && !last_accept)) && guard < 20000) begin
      if (!(valid_i && !last_accept)) begin
        if (offered < 1000 && ($urandom % 2) == 1) begin
          valid_i = 1'b1;
          data_i  = 32'h1000_0000 + offered;
          offered++;
        end else begin
          valid_i = 1'b0;
        end
      end
      ready_i = 1'($urandom % 2);
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (guard >= 20000) chk("rand_timeout", guard, 0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    if (guard >= 20) chk("drain_timeout", guard, 0);
    step(0, 0, 1, 0);
    chk("rand_count", delivered - base_deliv, 32'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
